// File: rtl/preg_freelist.sv
// Circular free list of physical register ids for rename: compacted multi-lane allocation,
// retire-side release, and flush recovery to the committed head. Define FREELIST_CHECK_EN for sim checks.
module preg_freelist #(
  parameter int unsigned PREG_NUM = 64,
  parameter int unsigned AREG_NUM = 32,
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEPTH    = PREG_NUM - AREG_NUM
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [WIDTH-1:0]                     alloc_req,
  input  logic                                 alloc_en,
  output logic                                 alloc_ok,
  output logic [WIDTH*$clog2(PREG_NUM)-1:0]    alloc_id,
  input  logic [WIDTH-1:0]                     free_valid,
  input  logic [WIDTH*$clog2(PREG_NUM)-1:0]    free_id,
  input  logic [WIDTH-1:0]                     retire_alloc,
  input  logic                                 flush,
  output logic [$clog2(DEPTH):0]               free_cnt
);

  localparam int unsigned IdW   = $clog2(PREG_NUM);
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  function automatic logic [PtrW-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [PtrW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + PtrW'(v[i]);
    return c;
  endfunction

  logic [IdW-1:0]  mem_q [DEPTH];
  logic [IdW-1:0]  mem_d [DEPTH];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [PtrW-1:0] commit_head_q, commit_head_d;

  logic [PtrW-1:0] req_cnt, push_cnt, retire_cnt;
  logic [PtrW-1:0] rd_ptr, wr_ptr;

  // MSB of the pointers separates a full list (tail - head = DEPTH) from an empty one.
  assign free_cnt   = tail_q - head_q;
  assign retire_cnt = popcnt(retire_alloc);

  // Lane i reads past the entries claimed by lower requesting lanes.
  always_comb begin
    req_cnt  = '0;
    rd_ptr   = '0;
    alloc_id = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rd_ptr = head_q + req_cnt;
      alloc_id[i*IdW +: IdW] = mem_q[rd_ptr[AddrW-1:0]];
      req_cnt = req_cnt + PtrW'(alloc_req[i]);
    end
  end

  assign alloc_ok = (free_cnt >= req_cnt);

  always_comb begin
    mem_d    = mem_q;
    push_cnt = '0;
    wr_ptr   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (free_valid[i]) begin
        wr_ptr = tail_q + push_cnt;
        mem_d[wr_ptr[AddrW-1:0]] = free_id[i*IdW +: IdW];
        push_cnt = push_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    head_d        = head_q;
    commit_head_d = commit_head_q + retire_cnt;
    tail_d        = tail_q + push_cnt;
    if (flush) begin
      head_d = commit_head_q + retire_cnt;
    end else if (alloc_en && alloc_ok) begin
      head_d = head_q + req_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q        <= '0;
      commit_head_q <= '0;
      tail_q        <= PtrW'(DEPTH);
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= IdW'(AREG_NUM + k);
    end else begin
      head_q        <= head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      mem_q         <= mem_d;
    end
  end

`ifdef FREELIST_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      if (int'(free_cnt) + int'(push_cnt) > int'(DEPTH))
        $error("preg_freelist: push overflow");
      for (int i = 0; i < WIDTH; i++) begin
        if (free_valid[i] && (int'(free_id[i*IdW +: IdW]) >= int'(PREG_NUM)))
          $error("preg_freelist: free_id out of range on lane %0d", i);
      end
      if (retire_cnt > PtrW'(head_q - commit_head_q))
        $error("preg_freelist: commit_head passing head");
      if (alloc_en && !flush && (req_cnt > free_cnt))
        $error("preg_freelist: alloc_en without stall while alloc_ok is low");
    end
  end
`else
  // Checks compiled out; behaviour is unchanged.
`endif

endmodule

// File: tb/tb_preg_freelist.sv
// Self-checking bench for preg_freelist: directed scenarios with literal expectations, then
// randomized legal traffic compared each cycle against an unbounded push-log model.
module tb_preg_freelist;

  localparam int PREG = 64;
  localparam int AREG = 32;
  localparam int W    = 4;
  localparam int D    = PREG - AREG;
  localparam int IW   = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic [W-1:0]    alloc_req;
  logic            alloc_en;
  logic            alloc_ok;
  logic [W*IW-1:0] alloc_id;
  logic [W-1:0]    free_valid;
  logic [W*IW-1:0] free_id;
  logic [W-1:0]    retire_alloc;
  logic            flush;
  logic [5:0]      free_cnt;

  preg_freelist #(.PREG_NUM(PREG), .AREG_NUM(AREG), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_en(alloc_en),
    .alloc_ok(alloc_ok), .alloc_id(alloc_id), .free_valid(free_valid), .free_id(free_id),
    .retire_alloc(retire_alloc), .flush(flush), .free_cnt(free_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: every id ever pushed, in push order, addressed by unbounded positions.
  int log_q[$];
  int alloc_pos, commit_pos;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pc(input logic [W-1:0] v);
    int c = 0;
    for (int i = 0; i < W; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int lane_id(input int i);
    return int'(alloc_id[i*IW +: IW]);
  endfunction

  task automatic model_reset();
    log_q = {};
    for (int k = 0; k < D; k++) log_q.push_back(AREG + k);
    alloc_pos  = 0;
    commit_pos = 0;
  endtask

  task automatic compare_model();
    int avail, pre, p;
    avail = log_q.size() - alloc_pos;
    chk("free_cnt", int'(free_cnt), avail);
    chk("alloc_ok", int'(alloc_ok), int'(pc(alloc_req) <= avail));
    pre = 0;
    for (int i = 0; i < W; i++) begin
      if (alloc_req[i]) begin
        p = alloc_pos + pre;
        if (p < log_q.size()) chk($sformatf("alloc_id[%0d]", i), lane_id(i), log_q[p]);
        pre++;
      end
    end
  endtask

  task automatic model_update();
    int nreq, nret;
    nreq = pc(alloc_req);
    nret = pc(retire_alloc);
    if (flush) alloc_pos = commit_pos + nret;
    else if (alloc_en && nreq <= log_q.size() - alloc_pos) alloc_pos += nreq;
    commit_pos += nret;
    for (int i = 0; i < W; i++)
      if (free_valid[i]) log_q.push_back(int'(free_id[i*IW +: IW]));
  endtask

  task automatic drive(input logic [W-1:0] req, input logic en, input logic [W-1:0] fv,
                       input logic [W*IW-1:0] fid, input logic [W-1:0] ret, input logic fl);
    alloc_req    = req;
    alloc_en     = en;
    free_valid   = fv;
    free_id      = fid;
    retire_alloc = ret;
    flush        = fl;
    #1;
  endtask

  task automatic tick();
    compare_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] trim(input logic [W-1:0] m, input int maxn);
    logic [W-1:0] r = m;
    for (int i = W - 1; i >= 0; i--) if (pc(r) > maxn) r[i] = 1'b0;
    return r;
  endfunction

  initial begin
    logic [W-1:0]    rq, fv, rt;
    logic [W*IW-1:0] fid;
    int              mx;
    reset = 1'b0;
    drive('0, 1'b0, '0, '0, '0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Reset state and first full-width allocation.
    drive('0, 1'b0, '0, '0, '0, 1'b0);
    chk("reset_free_cnt", int'(free_cnt), 32);
    chk("reset_alloc_ok", int'(alloc_ok), 1);
    tick();
    drive(4'b1111, 1'b1, '0, '0, '0, 1'b0);
    chk("first_id0", lane_id(0), 32);
    chk("first_id1", lane_id(1), 33);
    chk("first_id2", lane_id(2), 34);
    chk("first_id3", lane_id(3), 35);
    tick();
    drive(4'b1010, 1'b1, '0, '0, '0, 1'b0);
    chk("cnt_after_4", int'(free_cnt), 28);
    chk("sparse_lane1", lane_id(1), 36);
    chk("sparse_lane3", lane_id(3), 37);
    tick();
    drive('0, 1'b0, '0, '0, '0, 1'b0);
    chk("cnt_after_sparse", int'(free_cnt), 26);
    tick();
    repeat (6) begin
      drive(4'b1111, 1'b1, '0, '0, '0, 1'b0);
      tick();
    end
    drive(4'b0111, 1'b1, '0, '0, '0, 1'b0);
    chk("drained_cnt", int'(free_cnt), 2);
    chk("short_alloc_ok", int'(alloc_ok), 0);
    tick();
    // Allocate the last two while freeing 5 and 9: no bypass of freed ids.
    drive(4'b0011, 1'b1, 4'b0101, {6'd0, 6'd9, 6'd0, 6'd5}, '0, 1'b0);
    chk("stall_kept_cnt", int'(free_cnt), 2);
    chk("nobypass_id0", lane_id(0), 62);
    chk("nobypass_id1", lane_id(1), 63);
    tick();
    drive(4'b0001, 1'b1, '0, '0, '0, 1'b0);
    chk("cnt_after_swap", int'(free_cnt), 2);
    chk("wrap_id5", lane_id(0), 5);
    tick();
    drive(4'b0001, 1'b1, '0, '0, '0, 1'b0);
    chk("wrap_id9", lane_id(0), 9);
    tick();
    drive('0, 1'b0, '0, '0, '0, 1'b0);
    chk("empty_cnt", int'(free_cnt), 0);
    chk("empty_ok_noreq", int'(alloc_ok), 1);
    tick();

    // Asynchronous reset mid-cycle.
    #2 reset = 1'b0;
    #1;
    chk("async_reset_cnt", int'(free_cnt), 32);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Flush restores head to the committed head.
    drive(4'b1111, 1'b1, '0, '0, '0, 1'b0);
    tick();
    drive(4'b1111, 1'b1, '0, '0, '0, 1'b0);
    tick();
    drive('0, 1'b0, '0, '0, 4'b0011, 1'b0);
    chk("cnt_after_8", int'(free_cnt), 24);
    tick();
    drive('0, 1'b0, '0, '0, '0, 1'b1);
    tick();
    drive(4'b0001, 1'b1, '0, '0, '0, 1'b0);
    chk("flush_cnt", int'(free_cnt), 30);
    chk("flush_third_id", lane_id(0), 34);
    tick();
    drive(4'b1111, 1'b1, '0, '0, '0, 1'b0);
    tick();
    // Flush with a same-cycle allocation and retire: allocation dropped, head = commit + 1.
    drive(4'b1111, 1'b1, '0, '0, 4'b0001, 1'b1);
    tick();
    drive(4'b0001, 1'b0, '0, '0, '0, 1'b0);
    chk("flush_retire_cnt", int'(free_cnt), 29);
    chk("flush_retire_id", lane_id(0), 35);
    tick();

    // Randomized legal traffic.
    for (int n = 0; n < 3000; n++) begin
      rq = W'($urandom_range(0, 15));
      mx = alloc_pos - commit_pos;
      rt = trim(W'($urandom_range(0, 15)), mx > W ? W : mx);
      mx = D - (log_q.size() - commit_pos);
      fv = trim(W'($urandom_range(0, 15)), mx > W ? W : mx);
      for (int i = 0; i < W; i++) fid[i*IW +: IW] = IW'($urandom_range(0, PREG - 1));
      drive(rq, ($urandom_range(0, 9) < 7), fv, fid, rt, ($urandom_range(0, 19) == 0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
